// File: rtl/pulse_sequencer.sv
// pulse_sequencer
//   Schedules a burst of radar pulses by issuing one-cycle START_CALC/STOP_CALC strobes
//   to the LFM or PSK waveform generator (and to signal_mux, which watches the same
//   strobes). Pulse length, repetition period, pulse count and waveform select are
//   latched when a burst is accepted, so input changes during a burst have no effect.
//
// Ports
//   CLK                  system clock, rising edge
//   RESET                asynchronous, active-high reset
//   START                begin a burst (sampled only while idle)
//   ABORT                terminate the burst in progress
//   WAVE_SEL             0 = LFM, 1 = PSK
//   PULSE_LEN            pulse duration in clocks
//   PERIOD               pulse repetition interval in clocks
//   NUM_PULSES           pulses per burst
//   SIGN_LFM_START_CALC  one-cycle strobe, LFM pulse begins
//   SIGN_PSK_START_CALC  one-cycle strobe, PSK pulse begins
//   SIGN_LFM_STOP_CALC   one-cycle strobe, LFM pulse ends
//   SIGN_PSK_STOP_CALC   one-cycle strobe, PSK pulse ends
//   PULSE_ACTIVE         high from the start strobe up to the cycle before the stop strobe
//   BUSY                 burst in progress
//   DONE                 one-cycle strobe, burst completed normally
//   ERR                  one-cycle strobe, START rejected because of a bad configuration
module pulse_sequencer #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic             WAVE_SEL,
  input  logic [LEN_W-1:0] PULSE_LEN,
  input  logic [LEN_W-1:0] PERIOD,
  input  logic [CNT_W-1:0] NUM_PULSES,
  output logic             SIGN_LFM_START_CALC,
  output logic             SIGN_PSK_START_CALC,
  output logic             SIGN_LFM_STOP_CALC,
  output logic             SIGN_PSK_STOP_CALC,
  output logic             PULSE_ACTIVE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [1:0] {StIdle, StActive, StGap, StFinish} state_e;

  state_e           r_state;
  logic [LEN_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic             r_wave_sel;
  logic [LEN_W-1:0] r_pulse_len;
  logic [LEN_W-1:0] r_period;
  logic [CNT_W-1:0] r_num_pulses;

  logic r_lfm_start;
  logic r_psk_start;
  logic r_lfm_stop;
  logic r_psk_stop;
  logic r_pulse_active;
  logic r_busy;
  logic r_done;
  logic r_err;

  // One extra bit so PULSE_LEN + 2 cannot overflow near the top of the range.
  logic [LEN_W:0] w_min_period;
  logic           w_cfg_bad;

  assign w_min_period = {1'b0, PULSE_LEN} + {{(LEN_W-1){1'b0}}, 2'd2};
  assign w_cfg_bad    = (PULSE_LEN == '0) || (NUM_PULSES == '0) ||
                        ({1'b0, PERIOD} < w_min_period);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= StIdle;
      r_period_cnt   <= '0;
      r_pulse_cnt    <= '0;
      r_wave_sel     <= 1'b0;
      r_pulse_len    <= '0;
      r_period       <= '0;
      r_num_pulses   <= '0;
      r_lfm_start    <= 1'b0;
      r_psk_start    <= 1'b0;
      r_lfm_stop     <= 1'b0;
      r_psk_stop     <= 1'b0;
      r_pulse_active <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      r_lfm_start <= 1'b0;
      r_psk_start <= 1'b0;
      r_lfm_stop  <= 1'b0;
      r_psk_stop  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (START) begin
            r_wave_sel   <= WAVE_SEL;
            r_pulse_len  <= PULSE_LEN;
            r_period     <= PERIOD;
            r_num_pulses <= NUM_PULSES;
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_lfm_start    <= ~WAVE_SEL;
              r_psk_start    <= WAVE_SEL;
              r_pulse_active <= 1'b1;
              r_busy         <= 1'b1;
              r_period_cnt   <= LEN_W'(1);
              r_pulse_cnt    <= CNT_W'(1);
              r_state        <= StActive;
            end
          end
        end

        StActive: begin
          if (ABORT) begin
            // Close the open pulse so the generator and mux see a clean stop.
            r_lfm_stop     <= ~r_wave_sel;
            r_psk_stop     <= r_wave_sel;
            r_pulse_active <= 1'b0;
            r_busy         <= 1'b0;
            r_period_cnt   <= '0;
            r_pulse_cnt    <= '0;
            r_state        <= StIdle;
          end else begin
            r_period_cnt <= r_period_cnt + LEN_W'(1);
            if (r_period_cnt == r_pulse_len) begin
              r_lfm_stop     <= ~r_wave_sel;
              r_psk_stop     <= r_wave_sel;
              r_pulse_active <= 1'b0;
              r_state        <= (r_pulse_cnt == r_num_pulses) ? StFinish : StGap;
            end
          end
        end

        StGap: begin
          if (ABORT) begin
            // Also suppresses a start scheduled on this same edge.
            r_busy       <= 1'b0;
            r_period_cnt <= '0;
            r_pulse_cnt  <= '0;
            r_state      <= StIdle;
          end else if (r_period_cnt == r_period) begin
            r_lfm_start    <= ~r_wave_sel;
            r_psk_start    <= r_wave_sel;
            r_pulse_active <= 1'b1;
            r_period_cnt   <= LEN_W'(1);
            r_pulse_cnt    <= r_pulse_cnt + CNT_W'(1);
            r_state        <= StActive;
          end else begin
            r_period_cnt <= r_period_cnt + LEN_W'(1);
          end
        end

        StFinish: begin
          // DONE only for a burst that was not aborted during its final cycle.
          r_done       <= ~ABORT;
          r_busy       <= 1'b0;
          r_period_cnt <= '0;
          r_pulse_cnt  <= '0;
          r_state      <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign SIGN_LFM_START_CALC = r_lfm_start;
  assign SIGN_PSK_START_CALC = r_psk_start;
  assign SIGN_LFM_STOP_CALC  = r_lfm_stop;
  assign SIGN_PSK_STOP_CALC  = r_psk_stop;
  assign PULSE_ACTIVE        = r_pulse_active;
  assign BUSY                = r_busy;
  assign DONE                = r_done;
  assign ERR                 = r_err;

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Initiator side of the generator/mux start–stop protocol: schedules a burst of radar pulses by issuing one-cycle START_CALC/STOP_CALC strobes to the LFM or PSK generator and to signal_mux.
- Timing comes from a latched pulse length, repetition period and pulse count.
- Sits between the control/register interface and the waveform generators; signal_mux consumes the same strobes.

Parameters:
- LEN_W, 16, width of PULSE_LEN, PERIOD and the internal period counter
- CNT_W, 8, width of NUM_PULSES and the pulse counter

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  request to begin a burst; sampled only in IDLE
- ABORT  in  1  terminate the burst in progress
- WAVE_SEL  in  1  0 = LFM, 1 = PSK; latched on accept
- PULSE_LEN  in  LEN_W  pulse duration in clocks; latched on accept
- PERIOD  in  LEN_W  pulse repetition interval in clocks; latched on accept
- NUM_PULSES  in  CNT_W  pulses per burst; latched on accept
- SIGN_LFM_START_CALC  out  1  one-cycle strobe, LFM pulse begins
- SIGN_PSK_START_CALC  out  1  one-cycle strobe, PSK pulse begins
- SIGN_LFM_STOP_CALC  out  1  one-cycle strobe, LFM pulse ends
- SIGN_PSK_STOP_CALC  out  1  one-cycle strobe, PSK pulse ends
- PULSE_ACTIVE  out  1  high from start strobe through the cycle before the stop strobe
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle strobe, burst completed normally
- ERR  out  1  one-cycle strobe, START rejected on bad config

Behaviour:
- Reset:
  - Asynchronous RESET forces state IDLE, all counters to 0 and every output to 0.
  - Applies at any time, including mid-pulse. No stop strobe is emitted on reset.
- Outputs: all registered; strobes last exactly one CLK period.
- States: IDLE, ACTIVE, GAP, FINISH.
- IDLE:
  - If START is sampled high at edge E0, latch the configuration.
  - Reject if PULSE_LEN==0, NUM_PULSES==0 or PERIOD < PULSE_LEN+2. On reject, ERR is high for the cycle after E0 and the state stays IDLE.
  - Otherwise, after E0: the selected START_CALC strobe goes high, PULSE_ACTIVE=1, BUSY=1, the period counter loads 1, the pulse counter loads 1, and the state becomes ACTIVE.
- Period counter: increments every clock while BUSY. The pulse that started after edge Ek has these timings:
  - selected STOP_CALC strobe after edge Ek+PULSE_LEN; PULSE_ACTIVE falls with it; state becomes GAP.
  - next START_CALC strobe after edge Ek+PERIOD, if pulse counter < latched count; counter increments, period counter reloads 1, state becomes ACTIVE.
- Last pulse: when the pulse counter equals the latched count at the stop strobe, go to FINISH instead of GAP. DONE is high for the cycle after the stop strobe. BUSY falls at the same edge DONE is asserted; state returns to IDLE.
- PERIOD >= PULSE_LEN+2 guarantees at least one idle cycle between stop and the next start, which signal_mux needs to clear its stop flag.
- START while BUSY: ignored. Latched configuration is unaffected by input changes during a burst.
- Only the WAVE_SEL-selected strobe pair ever toggles within a burst. The other pair stays 0.
- ABORT (priority over normal timing, any non-IDLE state):
  - In ACTIVE: the selected STOP_CALC strobe fires after the next edge and PULSE_ACTIVE falls.
  - In GAP or FINISH: no strobe.
  - In all cases the state becomes IDLE and BUSY falls at the same edge; DONE is not asserted.
  - ABORT in IDLE is ignored.
- Simultaneous events:
  - ABORT coinciding with a scheduled stop: a single stop strobe, no DONE.
  - ABORT coinciding with a scheduled start: the start is suppressed.
  - START and ABORT together in IDLE: START processed normally.
- Counter width: PERIOD ≤ 2^LEN_W−1, so the counter never wraps. The pulse counter never exceeds NUM_PULSES ≤ 2^CNT_W−1.

Test Plan:
- Nominal LFM burst: WAVE_SEL=0, PULSE_LEN=4, PERIOD=10, NUM_PULSES=3, START at E0 → LFM_START strobes after E0, E10, E20; LFM_STOP after E4, E14, E24; DONE after E25; BUSY high E0..E25; PSK strobes stay 0.
- Config reject: PULSE_LEN=5, PERIOD=6 → ERR one cycle, no strobes, BUSY stays 0. Repeat with PULSE_LEN=0 and with NUM_PULSES=0 → same result.
- Abort mid-pulse: PSK, PULSE_LEN=8, PERIOD=20, NUM_PULSES=2, ABORT sampled at E3 → PSK_STOP strobe after E3, BUSY=0, no DONE, no second start.
- Ignored restart: while BUSY, pulse START and change PERIOD to 50 → burst timing unchanged (10-clock period kept).
- Reset mid-operation: assert RESET asynchronously during a pulse → all outputs 0 immediately; a subsequent START at E0 begins a fresh burst with correct timing.
- Minimum spacing: PULSE_LEN=1, PERIOD=3, NUM_PULSES=4 → start/stop strobes alternate with exactly one idle cycle between each stop and the next start; DONE after E11.
